// File: rtl/iob_uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and ID width helper.
package iob_uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_t;

    // A single requester still needs a 1-bit id so ports never collapse to zero width.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_uart_tx_arbiter_if.sv
// Byte-stream requester bus plus UART core transmit path seen by the arbiter.
interface iob_uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    // Requester i offers a byte with req_valid_i[i]; it is taken in the cycle
    // req_ready_o[i] is high (combinational, at most one bit set), and the
    // requester then presents its next byte. tx_wen_o is a single-cycle write to
    // the core, which reports tx_ready_i high while its transmitter is idle.
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ*DATA_W-1:0] req_data_i;
    logic [N_REQ-1:0]        req_last_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic                    tx_ready_i;
    logic [DATA_W-1:0]       tx_data_o;
    logic                    tx_wen_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
        output req_ready_o, tx_data_o, tx_wen_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, tx_ready_i,
        input  req_ready_o, tx_data_o, tx_wen_o
    );

endinterface

// File: rtl/iob_uart_tx_arbiter_rr_prio_sel.sv
// Combinational round-robin priority selector: first request above the pointer wins.
module iob_rr_prio_sel #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [ID_W-1:0] id_o,
    output logic            any_o
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        found = 1'b0;
        idx   = '0;
        // Offsets 1..N so the pointer itself is searched last.
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = idx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/iob_uart_tx_arbiter.sv
// Round-robin sequencer sharing the UART core transmit path between byte-stream requesters.
module iob_uart_tx_arbiter
    import iob_uart_tx_arbiter_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int DATA_W  = 8,
    parameter  int HOLDOFF = 2,
    localparam int ID_W    = id_width(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 cke_i,
    input  logic                 soft_rst_i,
    input  logic                 tx_en_i,
    iob_uart_tx_arbiter_if.slave bus,
    output logic                 busy_o,
    output logic                 lock_o,
    output logic [ID_W-1:0]      grant_id_o,
    output arb_state_t           dbg_state_o
);

    localparam int                CNT_W     = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLDOFF);
    localparam logic [ID_W-1:0]   PTR_RST   = ID_W'(N_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              lock_q, lock_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_dec;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_wen_q, tx_wen_d;

    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  win_gnt;
    logic [ID_W-1:0]   win_id;
    logic              win_any;
    logic              accept;

    // A held lock narrows arbitration to the requester that owns the packet.
    assign elig = lock_q ? (bus.req_valid_i & (N_REQ'(1) << grant_id_q)) : bus.req_valid_i;

    iob_rr_prio_sel #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_sel (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt),
        .id_o  (win_id),
        .any_o (win_any)
    );

    assign accept = (state_q == ST_IDLE) && tx_en_i && bus.tx_ready_i && cke_i
                    && !soft_rst_i && win_any;

    assign cnt_dec = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        lock_d     = lock_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_wen_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_data_d  = bus.req_data_i[win_id*DATA_W +: DATA_W];
                    grant_id_d = win_id;
                    ptr_d      = win_id;
                    lock_d     = !bus.req_last_i[win_id];
                    tx_wen_d   = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_d   = HOLD_LOAD;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // The core's ready is stale until the holdoff has run out.
                cnt_d = cnt_dec;
                if (cnt_dec == '0 && bus.tx_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PTR_RST;
            grant_id_q <= '0;
            lock_q     <= 1'b0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_wen_q   <= 1'b0;
        end else if (soft_rst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PTR_RST;
            grant_id_q <= '0;
            lock_q     <= 1'b0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_wen_q   <= 1'b0;
        end else if (cke_i) begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            lock_q     <= lock_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_wen_q   <= tx_wen_d;
        end
    end

    assign bus.req_ready_o = accept ? win_gnt : '0;
    assign bus.tx_data_o   = tx_data_q;
    assign bus.tx_wen_o    = tx_wen_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign lock_o          = lock_q;
    assign grant_id_o      = grant_id_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_iob_uart_tx_arbiter.sv
// Scenario bench for the UART transmit arbiter with per-requester byte queues and an expected-byte scoreboard.
module tb_iob_uart_tx_arbiter;
    import iob_uart_tx_arbiter_pkg::*;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int HOLDOFF = 2;
    localparam int ID_W    = 2;
    localparam int SPACING = HOLDOFF + 2;

    logic             clk = 1'b0;
    logic             arst;
    logic             cke;
    logic             soft_rst;
    logic             tx_en;
    logic             busy;
    logic             lock;
    logic [ID_W-1:0]  grant_id;
    arb_state_t       dbg_state;

    iob_uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    iob_uart_tx_arbiter #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .cke_i       (cke),
        .soft_rst_i  (soft_rst),
        .tx_en_i     (tx_en),
        .bus         (bus),
        .busy_o      (busy),
        .lock_o      (lock),
        .grant_id_o  (grant_id),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int                checks   = 0;
    int                failures = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W:0]   src_q[N_REQ][$];   // {last, byte}
    logic [N_REQ-1:0]  acc_seen = '0;
    int                rdy_err  = 0;

    // Sample the combinational accept mid-cycle and flag illegal strobes.
    always @(negedge clk) begin
        acc_seen = bus.req_ready_o;
        if (!arst && ($countones(bus.req_ready_o) > 1 ||
                      (bus.req_ready_o & ~bus.req_valid_i) != '0 ||
                      (dbg_state != ST_IDLE && bus.req_ready_o != '0)))
            rdy_err = rdy_err + 1;
    end

    // Requester models: pop on accept, then present the next queued byte.
    always @(posedge clk) begin
        logic [N_REQ-1:0]        v;
        logic [N_REQ-1:0]        l;
        logic [N_REQ*DATA_W-1:0] d;
        #1;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                v[i] = 1'b1;
                l[i] = src_q[i][0][DATA_W];
                d[i*DATA_W +: DATA_W] = src_q[i][0][DATA_W-1:0];
            end
        end
        bus.req_valid_i = v;
        bus.req_last_i  = l;
        bus.req_data_i  = d;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_soft_reset();
        @(posedge clk); #1 soft_rst = 1'b1;
        @(posedge clk); #1 soft_rst = 1'b0;
    endtask

    task automatic push_src(input int id, input logic last, input logic [DATA_W-1:0] b);
        src_q[id].push_back({last, b});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.tx_wen_o !== 1'b0) begin failures++; $display("FAIL reset_wen actual=%0b expected=0", bus.tx_wen_o); end
        checks++; if (bus.tx_data_o !== 8'h00) begin failures++; $display("FAIL reset_data actual=%0h expected=00", bus.tx_data_o); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%0b expected=0", busy); end
        checks++; if (lock !== 1'b0) begin failures++; $display("FAIL reset_lock actual=%0b expected=0", lock); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant actual=%0d expected=0", grant_id); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state actual=%0d expected=0", int'(dbg_state)); end
        @(posedge clk); #1 arst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL reset_ready actual=%b expected=0000", bus.req_ready_o); end
    endtask

    task automatic test_rr_fairness();
        int wen_cyc[$];
        logic [DATA_W-1:0] e;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N_REQ; i++) begin
                push_src(i, 1'b1, 8'hA0 + 8'(i));
                exp_q.push_back(8'hA0 + 8'(i));
            end
        for (int t = 0; t < 120 && wen_cyc.size() < 8; t++) begin
            @(negedge clk);
            if (bus.tx_wen_o) begin
                e = exp_q.pop_front();
                checks++; if (bus.tx_data_o !== e) begin failures++; $display("FAIL rr_data actual=%0h expected=%0h", bus.tx_data_o, e); end
                checks++; if (grant_id !== ID_W'(wen_cyc.size() % N_REQ)) begin failures++; $display("FAIL rr_grant actual=%0d expected=%0d", grant_id, wen_cyc.size() % N_REQ); end
                wen_cyc.push_back(cyc);
            end
        end
        checks++; if (wen_cyc.size() != 8) begin failures++; $display("FAIL rr_count actual=%0d expected=8", wen_cyc.size()); end
        for (int k = 1; k < wen_cyc.size(); k++) begin
            checks++; if (wen_cyc[k] - wen_cyc[k-1] != SPACING) begin failures++; $display("FAIL rr_spacing actual=%0d expected=%0d", wen_cyc[k] - wen_cyc[k-1], SPACING); end
        end
        repeat (6) @(negedge clk);
        checks++; if (rdy_err != 0) begin failures++; $display("FAIL rr_ready_rules actual=%0d expected=0", rdy_err); end
    endtask

    task automatic test_packet_lock();
        logic [DATA_W-1:0] e;
        logic       exp_lock[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0] exp_gid[6]  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
        int n = 0;
        pulse_soft_reset();
        @(posedge clk); #1;
        push_src(0, 1'b1, 8'h01); push_src(0, 1'b1, 8'h02);
        push_src(1, 1'b0, 8'h11); push_src(1, 1'b0, 8'h12); push_src(1, 1'b1, 8'h13);
        push_src(2, 1'b1, 8'h21);
        exp_q = '{8'h01, 8'h11, 8'h12, 8'h13, 8'h21, 8'h02};
        for (int t = 0; t < 100 && n < 6; t++) begin
            @(negedge clk);
            if (bus.tx_wen_o) begin
                e = exp_q.pop_front();
                checks++; if (bus.tx_data_o !== e) begin failures++; $display("FAIL lock_data actual=%0h expected=%0h", bus.tx_data_o, e); end
                checks++; if (lock !== exp_lock[n]) begin failures++; $display("FAIL lock_flag byte=%0h actual=%0b expected=%0b", e, lock, exp_lock[n]); end
                checks++; if (grant_id !== exp_gid[n]) begin failures++; $display("FAIL lock_grant byte=%0h actual=%0d expected=%0d", e, grant_id, exp_gid[n]); end
                n++;
            end
        end
        checks++; if (n != 6) begin failures++; $display("FAIL lock_count actual=%0d expected=6", n); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_holdoff_ready();
        logic [DATA_W-1:0] e;
        int w = -1, r, acc = -1, w2 = -1, stray = 0;
        pulse_soft_reset();
        @(posedge clk); #1;
        push_src(0, 1'b1, 8'h31); push_src(0, 1'b1, 8'h32);
        exp_q = '{8'h31, 8'h32};
        for (int t = 0; t < 20 && w < 0; t++) begin
            @(negedge clk);
            if (bus.tx_wen_o) begin
                w = cyc;
                e = exp_q.pop_front();
                checks++; if (bus.tx_data_o !== e) begin failures++; $display("FAIL hold_data1 actual=%0h expected=%0h", bus.tx_data_o, e); end
            end
        end
        checks++; if (w < 0) begin failures++; $display("FAIL hold_first_wen actual=timeout expected=pulse"); end
        @(posedge clk); #1;
        @(posedge clk); #1 bus.tx_ready_i = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.req_ready_o != '0 || bus.tx_wen_o || !busy) stray++;
            @(posedge clk); #1;
        end
        bus.tx_ready_i = 1'b1;
        r = cyc;
        checks++; if (stray != 0) begin failures++; $display("FAIL hold_wait_quiet actual=%0d expected=0", stray); end
        for (int t = 0; t < 12 && w2 < 0; t++) begin
            @(negedge clk);
            if (bus.req_ready_o != '0 && acc < 0) acc = cyc;
            if (bus.tx_wen_o) begin
                w2 = cyc;
                e = exp_q.pop_front();
                checks++; if (bus.tx_data_o !== e) begin failures++; $display("FAIL hold_data2 actual=%0h expected=%0h", bus.tx_data_o, e); end
            end
        end
        checks++; if (acc != r + 1) begin failures++; $display("FAIL hold_accept_cycle actual=%0d expected=%0d", acc, r + 1); end
        checks++; if (w2 != r + 2) begin failures++; $display("FAIL hold_wen_cycle actual=%0d expected=%0d", w2, r + 2); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_tx_en_gating();
        logic [DATA_W-1:0] e;
        int found = 0, wens = 0, stray = 0, n = 0;
        logic [1:0] exp_gid[2] = '{2'd1, 2'd2};
        pulse_soft_reset();
        @(posedge clk); #1;
        push_src(0, 1'b1, 8'h41); push_src(1, 1'b1, 8'h51); push_src(2, 1'b1, 8'h61);
        exp_q = '{8'h41, 8'h51, 8'h61};
        for (int t = 0; t < 20 && found == 0; t++) begin
            @(negedge clk);
            if (bus.req_ready_o != '0) begin
                found = 1;
                checks++; if (bus.req_ready_o !== 4'b0001) begin failures++; $display("FAIL en_first_ready actual=%b expected=0001", bus.req_ready_o); end
            end
        end
        checks++; if (found == 0) begin failures++; $display("FAIL en_first_accept actual=timeout expected=accept"); end
        @(posedge clk); #1 tx_en = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.req_ready_o != '0) stray++;
            if (bus.tx_wen_o) begin
                wens++;
                e = exp_q.pop_front();
                checks++; if (bus.tx_data_o !== e) begin failures++; $display("FAIL en_inflight_data actual=%0h expected=%0h", bus.tx_data_o, e); end
            end
        end
        checks++; if (wens != 1) begin failures++; $display("FAIL en_inflight_wen actual=%0d expected=1", wens); end
        checks++; if (stray != 0) begin failures++; $display("FAIL en_gated_ready actual=%0d expected=0", stray); end
        @(posedge clk); #1 tx_en = 1'b1;
        for (int t = 0; t < 40 && n < 2; t++) begin
            @(negedge clk);
            if (bus.tx_wen_o) begin
                e = exp_q.pop_front();
                checks++; if (bus.tx_data_o !== e) begin failures++; $display("FAIL en_resume_data actual=%0h expected=%0h", bus.tx_data_o, e); end
                checks++; if (grant_id !== exp_gid[n]) begin failures++; $display("FAIL en_resume_grant actual=%0d expected=%0d", grant_id, exp_gid[n]); end
                n++;
            end
        end
        checks++; if (n != 2) begin failures++; $display("FAIL en_resume_count actual=%0d expected=2", n); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_soft_reset_locked();
        logic [DATA_W-1:0] e;
        int w = -1, n = 0;
        pulse_soft_reset();
        @(posedge clk); #1;
        push_src(1, 1'b0, 8'h71); push_src(1, 1'b1, 8'h72);
        exp_q = '{8'h71};
        for (int t = 0; t < 20 && w < 0; t++) begin
            @(negedge clk);
            if (bus.tx_wen_o) begin
                w = cyc;
                e = exp_q.pop_front();
                checks++; if (bus.tx_data_o !== e) begin failures++; $display("FAIL srst_data1 actual=%0h expected=%0h", bus.tx_data_o, e); end
                checks++; if (lock !== 1'b1) begin failures++; $display("FAIL srst_lock_held actual=%0b expected=1", lock); end
            end
        end
        checks++; if (w < 0) begin failures++; $display("FAIL srst_first_wen actual=timeout expected=pulse"); end
        @(posedge clk); #1;
        soft_rst = 1'b1;
        src_q[1].delete();
        push_src(2, 1'b1, 8'h82); push_src(0, 1'b1, 8'h80);
        exp_q.push_back(8'h80); exp_q.push_back(8'h82);
        @(negedge clk);
        @(posedge clk); #1 soft_rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL srst_busy actual=%0b expected=0", busy); end
        checks++; if (lock !== 1'b0) begin failures++; $display("FAIL srst_lock actual=%0b expected=0", lock); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL srst_state actual=%0d expected=0", int'(dbg_state)); end
        checks++; if (bus.req_ready_o !== 4'b0001) begin failures++; $display("FAIL srst_first_grant actual=%b expected=0001", bus.req_ready_o); end
        for (int t = 0; t < 30 && n < 2; t++) begin
            @(negedge clk);
            if (bus.tx_wen_o) begin
                e = exp_q.pop_front();
                checks++; if (bus.tx_data_o !== e) begin failures++; $display("FAIL srst_order actual=%0h expected=%0h", bus.tx_data_o, e); end
                n++;
            end
        end
        checks++; if (n != 2) begin failures++; $display("FAIL srst_count actual=%0d expected=2", n); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_cke_freeze();
        logic [DATA_W-1:0] e;
        int w = -1, acc = -1, w2 = -1, stray = 0;
        pulse_soft_reset();
        @(posedge clk); #1;
        push_src(0, 1'b1, 8'h91); push_src(0, 1'b1, 8'h92);
        exp_q = '{8'h91, 8'h92};
        for (int t = 0; t < 20 && w < 0; t++) begin
            @(negedge clk);
            if (bus.tx_wen_o) begin
                w = cyc;
                e = exp_q.pop_front();
                checks++; if (bus.tx_data_o !== e) begin failures++; $display("FAIL cke_data1 actual=%0h expected=%0h", bus.tx_data_o, e); end
            end
        end
        checks++; if (w < 0) begin failures++; $display("FAIL cke_first_wen actual=timeout expected=pulse"); end
        @(posedge clk); #1 cke = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.req_ready_o != '0 || bus.tx_wen_o || dbg_state != ST_HOLD) stray++;
            @(posedge clk); #1;
        end
        cke = 1'b1;
        checks++; if (stray != 0) begin failures++; $display("FAIL cke_frozen actual=%0d expected=0", stray); end
        for (int t = 0; t < 12 && w2 < 0; t++) begin
            @(negedge clk);
            if (bus.req_ready_o != '0 && acc < 0) acc = cyc;
            if (bus.tx_wen_o) begin
                w2 = cyc;
                e = exp_q.pop_front();
                checks++; if (bus.tx_data_o !== e) begin failures++; $display("FAIL cke_data2 actual=%0h expected=%0h", bus.tx_data_o, e); end
            end
        end
        checks++; if (acc != w + SPACING - 1 + 5) begin failures++; $display("FAIL cke_accept_cycle actual=%0d expected=%0d", acc, w + SPACING - 1 + 5); end
        checks++; if (w2 != w + SPACING + 5) begin failures++; $display("FAIL cke_wen_cycle actual=%0d expected=%0d", w2, w + SPACING + 5); end
        repeat (6) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left actual=%0d expected=0", exp_q.size()); end
        checks++; if (rdy_err != 0) begin failures++; $display("FAIL ready_rules actual=%0d expected=0", rdy_err); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        arst           = 1'b1;
        cke            = 1'b1;
        soft_rst       = 1'b0;
        tx_en          = 1'b1;
        bus.tx_ready_i = 1'b1;
        test_reset();
        test_rr_fairness();
        test_packet_lock();
        test_holdoff_ready();
        test_tx_en_gating();
        test_soft_reset_locked();
        test_cke_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=still_running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
